mem_rw_arbiter: RTL
===================

Name: mem_rw_arbiter

Overview:
- Round-robin arbiter sharing the single simulation memory port between NUM_REQ requesters (e.g. icache refill, dcache refill, DMA).
- The memory port has one read channel and one write channel with 1-cycle registered read latency.
- Issues at most one operation (read or write) per cycle.
- Routes the read data and write acks back to the issuing requester.
- Sits between the cache/DMA refill logic and the memory helper.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- IDX_W, 64, width of word index
- DATA_W, 64, width of data and mask

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_wen  in  NUM_REQ  1 = write, 0 = read
- req_index  in  NUM_REQ*IDX_W  packed word indices; requester i uses bits [i*IDX_W +: IDX_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_wmask  in  NUM_REQ*DATA_W  packed bit-granular write mask
- resp_valid  out  NUM_REQ  one-hot response strobe; no backpressure
- resp_is_write  out  1  response is a write ack
- resp_data  out  DATA_W  read data, shared by all requesters
- mem_stall  in  1  1 = issue nothing this cycle
- mem_enable  out  1  enable to the memory port
- mem_r_enable  out  1  read strobe
- mem_r_index  out  IDX_W  read index
- mem_r_data  in  DATA_W  read data, valid the cycle after mem_r_enable
- mem_w_enable  out  1  write strobe
- mem_w_index  out  IDX_W  write index
- mem_w_data  out  DATA_W  write data
- mem_w_mask  out  DATA_W  write mask

Behaviour:
- Reset values:
  - rr_ptr = 0.
  - All req_ready, resp_valid, mem_r_enable, mem_w_enable = 0.
  - resp_is_write = 0; resp_data = 0.
  - mem_enable = 0 during reset, 1 otherwise.
- Arbitration (combinational, cycle T):
  - If mem_stall = 1 or reset = 1, no grant.
  - Otherwise grant the first requester with req_valid set, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready is one-hot on the granted requester.
  - A handshake is req_valid & req_ready in the same cycle.
- Issue, cycle T:
  - Granted read: mem_r_enable = 1, mem_r_index = that requester's index; mem_w_enable = 0.
  - Granted write: mem_w_enable = 1, with that requester's index, data and mask; mem_r_enable = 0.
  - Read and write are never issued in the same cycle.
  - Index, data and mask outputs are don't-care when not strobed; drive them 0.
- Pointer update at edge T: rr_ptr <= (granted id + 1) mod NUM_REQ. Unchanged on no grant.
- Response tracking:
  - Registered at edge T: pend_valid, pend_id, pend_write.
  - In cycle T+1: resp_valid[pend_id] = pend_valid.
  - resp_is_write = pend_write.
  - resp_data = mem_r_data for reads, 0 for writes.
  - Latency is exactly 1 cycle.
  - Throughput is 1 operation per cycle; back-to-back grants are allowed.
- Ordering:
  - Operations complete in grant order.
  - A write at T followed by a read of the same index at T+1 returns the new data.
- mem_stall:
  - Blocks new grants only.
  - An in-flight response still appears at T+1.
- Reset mid-operation:
  - A pending response is dropped; resp_valid = 0 in the cycle after reset.
  - rr_ptr returns to 0.
- A requester must hold valid and payload stable until ready. Dropping valid before the handshake is permitted and issues nothing.

Optional Feature:
- Macro: MEM_RW_ARB_PERF_EN.
- When defined, the block adds:
  - Output perf_grant_cnt, NUM_REQ*32 bits: per-requester saturating grant counters.
  - Output perf_conflict_cnt, 32 bits: counts cycles with at least 2 req_valid bits set and no stall.
  - All counters clear on reset and saturate at 0xFFFFFFFF.
- When undefined, these ports and the counter logic do not exist; behaviour is otherwise identical.

Test Plan:
1. Single read:
   - Stimulus: memory holds index 0x10 = 0xDEADBEEF; req 1 reads 0x10 at T.
   - Expected: req_ready = 3'b010 at T; mem_r_enable = 1 with index 0x10; at T+1, resp_valid = 3'b010, resp_data = 0xDEADBEEF, resp_is_write = 0.
2. Write then read:
   - Stimulus: req 0 writes index 0x20, data 0x1122334455667788, mask 0x00000000FFFFFFFF at T (old value 0); req 0 reads 0x20 at T+1.
   - Expected: read response at T+2 returns 0x0000000055667788.
3. Round-robin:
   - Stimulus: all 3 requesters continuously valid from reset.
   - Expected: grants 0, 1, 2, 0, 1, 2 on consecutive cycles; responses one-hot in the same order, one cycle later.
4. Stall:
   - Stimulus: req 2 valid; mem_stall = 1 for cycles T..T+2, with a read grant issued at T-1.
   - Expected: resp_valid for the T-1 read at T; no req_ready or mem strobes during T..T+2; grant to req 2 at T+3.
5. Reset mid-flight:
   - Stimulus: read granted at T; reset asserted at T+1.
   - Expected: resp_valid = 0 at T+1 and T+2; first grant after reset deasserts goes to the lowest valid id.
6. Perf (MEM_RW_ARB_PERF_EN defined):
   - Stimulus: scenario 3 for 6 cycles.
   - Expected: perf_grant_cnt = {2, 2, 2}; perf_conflict_cnt = 6.

Source files
------------

// File: rtl/mem_rw_arbiter.sv
// ---------------------------------------------------------------------------
// mem_rw_arbiter
//
// Round-robin arbiter that shares one memory port between NUM_REQ requesters.
// The memory port has one read channel and one write channel. Reads have a
// 1-cycle registered latency. At most one operation (read or write) is issued
// per cycle. Each response is routed back to the requester that issued it.
//
// Optional feature: define MEM_RW_ARB_PERF_EN to add saturating performance
// counters (perf_grant_cnt, perf_conflict_cnt). When it is undefined, those
// ports and counters do not exist.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   req_valid/ready     per-requester handshake (ready is one-hot or zero)
//   req_wen             per-requester 1 = write, 0 = read
//   req_index/wdata/    packed payloads; requester i uses slice i
//     wmask
//   resp_valid          one-hot response strobe, one cycle after the grant
//   resp_is_write       response is a write ack
//   resp_data           read data (0 for write acks)
//   mem_stall           hold off new grants this cycle
//   mem_enable          memory port enable (low only during reset)
//   mem_r_*             read strobe/index, read data returns next cycle
//   mem_w_*             write strobe/index/data/bit mask
//   perf_grant_cnt      (MEM_RW_ARB_PERF_EN) per-requester grant counters
//   perf_conflict_cnt   (MEM_RW_ARB_PERF_EN) contended, unstalled cycles
// ---------------------------------------------------------------------------
module mem_rw_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 64,
    parameter int DATA_W  = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_wen,
    input  logic [NUM_REQ*IDX_W-1:0]  req_index,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*DATA_W-1:0] req_wmask,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic                      resp_is_write,
    output logic [DATA_W-1:0]         resp_data,
    input  logic                      mem_stall,
    output logic                      mem_enable,
    output logic                      mem_r_enable,
    output logic [IDX_W-1:0]          mem_r_index,
    input  logic [DATA_W-1:0]         mem_r_data,
    output logic                      mem_w_enable,
    output logic [IDX_W-1:0]          mem_w_index,
    output logic [DATA_W-1:0]         mem_w_data,
    output logic [DATA_W-1:0]         mem_w_mask
`ifdef MEM_RW_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]     perf_grant_cnt,
    output logic [31:0]               perf_conflict_cnt
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ID_W-1:0]   pend_id_q, pend_id_d;
    logic              pend_write_q, pend_write_d;

    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    logic              sel_wen;
    logic [IDX_W-1:0]  sel_index;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] sel_wmask;

    // Round-robin search starting at rr_ptr; the outer loop is the priority
    // order, so the first hit in k wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        if (!reset && !mem_stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                for (int c = 0; c < NUM_REQ; c++) begin
                    if (!grant_vld && req_valid[c] &&
                        (c == (int'(rr_ptr_q) + k) % NUM_REQ)) begin
                        grant_vld = 1'b1;
                        grant_id  = ID_W'(c);
                    end
                end
            end
        end
    end

    // Payload selection for the granted requester.
    always_comb begin
        req_ready = '0;
        sel_wen   = 1'b0;
        sel_index = '0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int c = 0; c < NUM_REQ; c++) begin
            if (grant_vld && (grant_id == ID_W'(c))) begin
                req_ready[c] = 1'b1;
                sel_wen      = req_wen[c];
                sel_index    = req_index[c*IDX_W +: IDX_W];
                sel_wdata    = req_wdata[c*DATA_W +: DATA_W];
                sel_wmask    = req_wmask[c*DATA_W +: DATA_W];
            end
        end
    end

    // Issue: read and write strobes are mutually exclusive by construction.
    always_comb begin
        mem_enable   = ~reset;
        mem_r_enable = grant_vld & ~sel_wen;
        mem_w_enable = grant_vld & sel_wen;
        mem_r_index  = mem_r_enable ? sel_index : '0;
        mem_w_index  = mem_w_enable ? sel_index : '0;
        mem_w_data   = mem_w_enable ? sel_wdata : '0;
        mem_w_mask   = mem_w_enable ? sel_wmask : '0;
    end

    // Next-state: pointer moves past the winner; pending slot tracks the
    // single in-flight operation.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
        pend_valid_d = grant_vld;
        pend_id_d    = grant_id;
        pend_write_d = grant_vld & sel_wen;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= '0;
            pend_write_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            pend_write_q <= pend_write_d;
        end
    end

    // Responses are masked by reset so an in-flight operation is dropped in
    // the very cycle reset is seen.
    always_comb begin
        resp_valid = '0;
        for (int c = 0; c < NUM_REQ; c++) begin
            if (pend_valid_q && !reset && (pend_id_q == ID_W'(c))) begin
                resp_valid[c] = 1'b1;
            end
        end
        resp_is_write = pend_valid_q & pend_write_q & ~reset;
        resp_data     = (pend_valid_q && !pend_write_q && !reset) ? mem_r_data : '0;
    end

`ifdef MEM_RW_ARB_PERF_EN
    logic [31:0] grant_cnt_q [NUM_REQ];
    logic [31:0] grant_cnt_d [NUM_REQ];
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        for (int c = 0; c < NUM_REQ; c++) begin
            grant_cnt_d[c] = grant_cnt_q[c];
            if (grant_vld && (grant_id == ID_W'(c)) && (grant_cnt_q[c] != '1)) begin
                grant_cnt_d[c] = grant_cnt_q[c] + 32'd1;
            end
            perf_grant_cnt[c*32 +: 32] = grant_cnt_q[c];
        end
        conflict_cnt_d = conflict_cnt_q;
        if (($countones(req_valid) >= 2) && !mem_stall && !reset &&
            (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
        perf_conflict_cnt = conflict_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_REQ; c++) grant_cnt_q[c] <= '0;
            conflict_cnt_q <= '0;
        end else begin
            for (int c = 0; c < NUM_REQ; c++) grant_cnt_q[c] <= grant_cnt_d[c];
            conflict_cnt_q <= conflict_cnt_d;
        end
    end
`endif

endmodule
